// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate, direct-mapped data cache controller.
// One outstanding CPU request; backing store is a synchronous word RAM
// with one cycle of read latency. Line moves are word-serial.
//
// state | meaning
// IDLE  | waiting for cpu_req; hits resolve here in one edge
// WB    | writing the dirty victim line back, one word per cycle
// FILL  | reading the requested line, one word per cycle plus a drain cycle
// RESP  | one-cycle cpu_ack with the addressed word on cpu_rdata
module dcache_ctrl #(
  parameter int LINES = 8,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 32 - OFF_W - IDX_W;
  localparam int PTR_W = IDX_W + OFF_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WB   = 2'd1;
  localparam logic [1:0] FILL = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  // Beat counter runs 0..WORDS-1 in WB and 0..WORDS in FILL (extra drain beat).
  localparam logic [OFF_W:0] WB_LAST  = (OFF_W+1)'(WORDS - 1);
  localparam logic [OFF_W:0] FILL_END = (OFF_W+1)'(WORDS);

  logic [1:0]       state;
  logic [OFF_W:0]   beat;
  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES*WORDS];

  // The request is latched on acceptance so WB/FILL/RESP never depend on
  // the CPU keeping its inputs stable.
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_we;

  logic [OFF_W-1:0] cpu_off, req_off, beat_off, fill_off;
  logic [IDX_W-1:0] cpu_idx, req_idx;
  logic [TAG_W-1:0] cpu_tag, req_tag;
  logic [PTR_W-1:0] cpu_ptr, req_ptr, wb_ptr, fill_ptr;
  logic             hit, victim_dirty;

  assign cpu_off  = cpu_addr[OFF_W-1:0];
  assign cpu_idx  = cpu_addr[OFF_W +: IDX_W];
  assign cpu_tag  = cpu_addr[31 -: TAG_W];
  assign req_off  = req_addr[OFF_W-1:0];
  assign req_idx  = req_addr[OFF_W +: IDX_W];
  assign req_tag  = req_addr[31 -: TAG_W];
  assign beat_off = beat[OFF_W-1:0];
  // RAM data lags the address by one beat, so the word landing now belongs
  // to the previous beat.
  assign fill_off = beat_off - 1'b1;

  assign cpu_ptr  = {cpu_idx, cpu_off};
  assign req_ptr  = {req_idx, req_off};
  assign wb_ptr   = {req_idx, beat_off};
  assign fill_ptr = {req_idx, fill_off};

  assign hit          = valid[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
  assign victim_dirty = valid[cpu_idx] && dirty[cpu_idx];

  // Control state, line status bits, request latch and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      valid     <= '0;
      dirty     <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_we    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
            req_we    <= cpu_we;
            beat      <= '0;
            if (hit) begin
              state <= RESP;
              if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
              if (cpu_we) dirty[cpu_idx] <= 1'b1;
            end else begin
              state <= victim_dirty ? WB : FILL;
              if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            end
          end
        end
        WB: begin
          if (beat == WB_LAST) begin
            beat  <= '0;
            state <= FILL;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        FILL: begin
          if (beat == FILL_END) begin
            valid[req_idx] <= 1'b1;
            dirty[req_idx] <= 1'b0;
            state          <= RESP;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        default: begin
          if (req_we) dirty[req_idx] <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  // Tag and data storage: hit writes, fill capture, and the post-fill write merge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      case (state)
        IDLE: begin
          if (cpu_req && hit && cpu_we) data_mem[cpu_ptr] <= cpu_wdata;
        end
        FILL: begin
          if (beat != '0) data_mem[fill_ptr] <= mem_dout;
          if (beat == FILL_END) tag_mem[req_idx] <= req_tag;
        end
        RESP: begin
          if (req_we) data_mem[req_ptr] <= req_wdata;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode straight from state so reset and IDLE drive all zeros.
  always_comb begin
    cpu_ack   = 1'b0;
    cpu_rdata = '0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    case (state)
      WB: begin
        mem_we   = 1'b1;
        mem_addr = {tag_mem[req_idx], req_idx, beat_off};
        mem_din  = data_mem[wb_ptr];
      end
      FILL: begin
        if (beat != FILL_END) mem_addr = {req_tag, req_idx, beat_off};
      end
      RESP: begin
        cpu_ack   = 1'b1;
        // A write's merge lands at the end of RESP; show the merged value now.
        cpu_rdata = req_we ? req_wdata : data_mem[req_ptr];
      end
      default: ;
    endcase
  end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter LINES, default 8: number of direct-mapped lines, power of two.
REQ-002 Parameter WORDS, default 4: 32-bit words per line, power of two.
REQ-003 clk  input  1  single clock; all state changes on posedge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 cpu_req  input  1  access request, held high with stable addr/we/wdata until cpu_ack.
REQ-006 cpu_we  input  1  1 = write, 0 = read.
REQ-007 cpu_addr  input  32  word address: offset [log2(WORDS)-1:0], index next log2(LINES) bits, tag remaining upper bits.
REQ-008 cpu_wdata  input  32  write data.
REQ-009 cpu_rdata  output  32  read data, valid only while cpu_ack=1.
REQ-010 cpu_ack  output  1  one-cycle completion pulse.
REQ-011 mem_we  output  1  write strobe to the synchronous word RAM.
REQ-012 mem_addr  output  32  word address to RAM.
REQ-013 mem_din  output  32  write data to RAM.
REQ-014 mem_dout  input  32  RAM read data, valid one cycle after mem_addr is presented.
REQ-015 hit_cnt  output  16  completed hits, saturating.
REQ-016 miss_cnt  output  16  completed misses, saturating.

Function
REQ-017 The block SHALL be a write-back, write-allocate, direct-mapped cache with per-line valid, dirty, tag and WORDS data words.
REQ-018 FSM states SHALL be IDLE, WB, FILL, RESP.
REQ-019 IDLE with cpu_req=0 SHALL stay IDLE with mem_we=0 and cpu_ack=0.
REQ-020 IDLE with cpu_req=1 and a hit (valid and tag match) SHALL go to RESP; on a write hit, the word is written and dirty set at that edge.
REQ-021 IDLE with cpu_req=1 and a miss SHALL go to WB if the victim is valid and dirty, else to FILL; miss_cnt increments at this edge.
REQ-022 WB SHALL last exactly WORDS cycles, beat k: mem_we=1, mem_addr={victim tag, index, k}, mem_din=victim word k, k ascending from 0; then go to FILL.
REQ-023 FILL SHALL last exactly WORDS+1 cycles: beats 0..WORDS-1 drive mem_we=0, mem_addr={req tag, index, k}; mem_dout is captured into word k one cycle later; the extra cycle drains the last word.
REQ-024 On leaving FILL, the line SHALL become valid with the new tag and dirty=0; it then goes to RESP, where a pending write merges cpu_wdata into the line and sets dirty.
REQ-025 RESP SHALL assert cpu_ack=1 for exactly one cycle, drive cpu_rdata with the addressed word (post-merge for writes), and return to IDLE.
REQ-026 hit_cnt SHALL increment on the IDLE->RESP hit edge only; both counters saturate at 16'hFFFF.
REQ-027 Latency from the IDLE request edge to cpu_ack SHALL be: hit 1 cycle; clean miss WORDS+2 cycles; dirty miss 2*WORDS+2 cycles (defaults: 1/6/10).
REQ-028 cpu_ack SHALL never assert outside RESP, and mem_we SHALL never assert outside WB.
REQ-029 A new request presented in the IDLE cycle right after RESP SHALL be accepted (back-to-back).
REQ-030 Fill data SHALL be stored exactly as returned, including zeros for addresses the RAM treats as out of range.
REQ-031 cpu_req dropped before ack is illegal; behaviour is undefined except that no extra mem_we beats beyond the current WB sequence SHALL occur.

Reset
REQ-032 While rst=1 at a posedge: state IDLE; all valid and dirty bits 0; cpu_ack=0; mem_we=0; mem_addr=0; mem_din=0; cpu_rdata=0; hit_cnt=0; miss_cnt=0.
REQ-033 Reset mid-WB or mid-FILL SHALL abort immediately with no further mem_we beats; tag and data contents need not be cleared.

Verification
REQ-034 Reset, then read addr 0x10 (RAM word 0x10..0x13 = 1..4) -> 5 FILL cycles reading 0x10..0x13, ack 6 cycles after request, rdata=1, miss_cnt=1.
REQ-035 Read 0x12 immediately after -> ack 1 cycle later, rdata=3, hit_cnt=1, no mem activity.
REQ-036 Write 0x11 with 0xDEAD (hit) -> ack after 1 cycle, mem_we stays 0; then read 0x30 (same index, different tag) -> 4 WB beats writing 0x10..0x13 with data 1,0xDEAD,3,4, then FILL of 0x30..0x33, ack at cycle 10.
REQ-037 Assert rst on WB beat 2 -> mem_we=0 from the next cycle; afterwards a read of 0x10 misses.
REQ-038 Present 0x10000 read (RAM returns 0) -> fills zeros, rdata=0, no X on any output.
REQ-039 Back-to-back hit reads with cpu_req held continuously and addr changed at each ack -> one ack every 2 cycles, correct data each.
